// File: rtl/core_s1_fetch.sv
// core_s1_fetch -- stage-1 instruction fetch.
// Issues sequential fetch requests to the MMU with at most one outstanding.
// A request may overlap the response of the previous one. Responses go into
// an in-order fetch queue that feeds stage 2.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   redirect_valid/addr       branch/trap redirect; flushes the queue and reloads the PC
//   halt_req                  level; blocks new requests while high
//   fetch_req_valid/ready/addr  MMU request handshake
//   fetch_rsp_valid/instr/fault MMU response; in order, cannot be stalled
//   s2_valid/ready/pc/instr/fault  handoff of the queue head to stage 2
//   halted                    halt_req high and nothing outstanding
//   fq_count                  fetch-queue occupancy
module core_s1_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4            // power of two, >= 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_addr,
    input  logic                          halt_req,
    output logic                          fetch_req_valid,
    input  logic                          fetch_req_ready,
    output logic [31:0]                   fetch_req_addr,
    input  logic                          fetch_rsp_valid,
    input  logic [31:0]                   fetch_rsp_instr,
    input  logic                          fetch_rsp_fault,
    output logic                          s2_valid,
    input  logic                          s2_ready,
    output logic [31:0]                   s2_pc,
    output logic [31:0]                   s2_instr,
    output logic                          s2_fault,
    output logic                          halted,
    output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FQ_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD, FAULTED} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fq_entry_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;       // address of the request currently outstanding
    fq_entry_t   fq_mem [FQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW:0] occ;

    logic rsp_in_wait, issue_slot, req_fire, push, pop;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^redirect_addr[1:0];

    assign rsp_in_wait = (state == WAIT) && fetch_rsp_valid;

    // A faulting response stops issue in the same cycle, so no request is
    // left in flight behind a fault.
    assign issue_slot = (state == FETCH) || (rsp_in_wait && !fetch_rsp_fault);

    // The in-flight request counts against queue space so its response
    // always has a slot to land in.
    assign occ = {1'b0, fq_count} + {{CW{1'b0}}, (state == WAIT)};

    assign fetch_req_valid = !rst && issue_slot && !halt_req && !redirect_valid
                             && (occ < DEPTH_L);
    assign fetch_req_addr  = fetch_pc;
    assign req_fire        = fetch_req_valid && fetch_req_ready;

    assign push     = !rst && !redirect_valid && rsp_in_wait;
    assign s2_valid = !rst && (fq_count != '0) && !redirect_valid;
    assign pop      = s2_valid && s2_ready;

    assign halted = !rst && halt_req && (state != WAIT) && (state != DISCARD);

    assign s2_pc    = fq_mem[rd_ptr].pc;
    assign s2_instr = fq_mem[rd_ptr].instr;
    assign s2_fault = fq_mem[rd_ptr].fault;

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            // A request still in flight must have its response dropped.
            if ((state == WAIT || state == DISCARD) && !fetch_rsp_valid)
                state_nxt = DISCARD;
            else
                state_nxt = FETCH;
        end else begin
            case (state)
                FETCH:   if (req_fire) state_nxt = WAIT;
                WAIT:    if (fetch_rsp_valid) begin
                             if (fetch_rsp_fault)  state_nxt = FAULTED;
                             else if (req_fire)    state_nxt = WAIT;
                             else                  state_nxt = FETCH;
                         end
                DISCARD: if (fetch_rsp_valid) state_nxt = FETCH;
                FAULTED: state_nxt = FAULTED;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fq_count <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid)
                fetch_pc <= {redirect_addr[31:2], 2'b00};
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            if (req_fire)
                req_pc <= fetch_pc;
            if (redirect_valid) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fq_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop)
                    fq_count <= fq_count + CNT_ONE;
                else if (!push && pop)
                    fq_count <= fq_count - CNT_ONE;
            end
        end
    end

    // Storage is cleared on reset so stage 2 sees zeros before the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++)
                fq_mem[i] <= '0;
        end else if (push) begin
            fq_mem[wr_ptr] <= '{pc: req_pc, instr: fetch_rsp_instr, fault: fetch_rsp_fault};
        end
    end

endmodule

// File: tb/tb_core_s1_fetch.sv
module tb_core_s1_fetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        halt_req = 1'b0;
    logic        fetch_req_valid;
    logic        fetch_req_ready = 1'b0;
    logic [31:0] fetch_req_addr;
    logic        fetch_rsp_valid = 1'b0;
    logic [31:0] fetch_rsp_instr = '0;
    logic        fetch_rsp_fault = 1'b0;
    logic        s2_valid;
    logic        s2_ready = 1'b0;
    logic [31:0] s2_pc, s2_instr;
    logic        s2_fault;
    logic        halted;
    logic [$clog2(DEPTH+1)-1:0] fq_count;

    always #5 clk = ~clk;

    core_s1_fetch #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .halt_req(halt_req),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_addr(fetch_req_addr),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_instr(fetch_rsp_instr),
        .fetch_rsp_fault(fetch_rsp_fault),
        .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_pc(s2_pc),
        .s2_instr(s2_instr), .s2_fault(s2_fault),
        .halted(halted), .fq_count(fq_count)
    );

    // In-flight MMU transaction and expected stage-2 entry.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        int          rdy;
        logic        stale;   // redirected away: its response must be dropped
    } mmu_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    mmu_t        mmu[$];
    ent_t        exp_q[$];
    logic [31:0] acc_addrs[$];

    int checks = 0, failures = 0;
    int cyc = 0, acc_cnt = 0, pop_cnt = 0, first_acc = -1, first_pop = -1;
    int lat_min = 1, lat_max = 1, fault_pct = 0;
    logic [31:0] model_pc = RPC;
    logic [31:0] fault_addr = 32'h2;
    logic [31:0] last_pop_pc = '0;
    logic        last_pop_fault = 1'b0;
    logic        faulted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i >= 0 && i < acc_addrs.size()) return acc_addrs[i];
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // MMU: answers the oldest accepted request once its latency has elapsed.
    always @(posedge clk) begin
        #1;
        if (mmu.size() != 0 && mmu[0].rdy <= cyc) begin
            fetch_rsp_valid = 1'b1;
            fetch_rsp_instr = mmu[0].instr;
            fetch_rsp_fault = mmu[0].fault;
        end else begin
            fetch_rsp_valid = 1'b0;
            fetch_rsp_instr = $urandom;
            fetch_rsp_fault = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares the DUT against the reference state and pops the
    // scoreboard on each stage-2 handshake.
    always @(negedge clk) begin : monitor
        bit   busy, live, exp_rv;
        ent_t e;
        if (!rst) begin
            busy   = (mmu.size() != 0);
            live   = busy && !mmu[0].stale;
            exp_rv = !halt_req && !redirect_valid && !faulted
                     && (!busy || (live && fetch_rsp_valid && !mmu[0].fault))
                     && (exp_q.size() + (live ? 1 : 0) < DEPTH);
            chk("req_valid", 32'(fetch_req_valid), 32'(exp_rv));
            chk("halted", 32'(halted), 32'(halt_req && !busy));
            chk("fq_count", 32'(fq_count), 32'(exp_q.size()));
            chk("s2_valid", 32'(s2_valid), 32'((exp_q.size() != 0) && !redirect_valid));
            if (s2_valid && s2_ready) begin
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL s2_pop: got pc %h with nothing expected at t=%0t", s2_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("s2_pc", s2_pc, e.pc);
                    chk("s2_instr", s2_instr, e.instr);
                    chk("s2_fault", 32'(s2_fault), 32'(e.fault));
                    last_pop_pc    = s2_pc;
                    last_pop_fault = s2_fault;
                end
            end
        end
    end

    // Reference model: runs after the monitor within each cycle and applies
    // the cycle's events (response, redirect, acceptance).
    always @(negedge clk) begin : model
        mmu_t m;
        ent_t e;
        #1;
        if (rst) begin
            exp_q.delete();
            mmu.delete();
            acc_addrs.delete();
            model_pc = RPC;
            faulted  = 1'b0;
        end else begin
            if (fetch_rsp_valid && mmu.size() != 0) begin
                m = mmu.pop_front();
                if (!m.stale && !redirect_valid) begin
                    e.pc = m.addr; e.instr = m.instr; e.fault = m.fault;
                    exp_q.push_back(e);
                    if (m.fault) faulted = 1'b1;
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                foreach (mmu[i]) mmu[i].stale = 1'b1;
                model_pc = redirect_addr & 32'hFFFF_FFFC;
                faulted  = 1'b0;
            end
            if (fetch_req_valid && fetch_req_ready) begin
                chk("req_addr", fetch_req_addr, model_pc);
                m.addr  = model_pc;
                m.instr = $urandom;
                m.fault = (model_pc == fault_addr) || (int'($urandom_range(0, 99)) < fault_pct);
                m.rdy   = cyc + int'($urandom_range(lat_min, lat_max));
                m.stale = 1'b0;
                mmu.push_back(m);
                acc_cnt++;
                acc_addrs.push_back(model_pc);
                if (first_acc < 0) first_acc = cyc;
                model_pc = model_pc + 32'd4;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 100) begin
            step(1);
            n++;
        end
        if (acc_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL wait_acc: got %0d accepts, required %0d", acc_cnt, target);
        end
    endtask

    initial begin
        int a0, n0;
        // Reset: outputs quiet even with halt_req high.
        rst = 1'b1; halt_req = 1'b1; fetch_req_ready = 1'b1; s2_ready = 1'b1;
        step(2);
        @(negedge clk);
        chk("rst_req_valid", 32'(fetch_req_valid), 32'd0);
        chk("rst_s2_valid", 32'(s2_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fq_count", 32'(fq_count), 32'd0);
        chk("rst_pc", fetch_req_addr, RPC);
        step(1);
        rst = 1'b0; halt_req = 1'b0; fetch_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_s2_pc", s2_pc, 32'd0);
        chk("rst_s2_instr", s2_instr, 32'd0);
        chk("rst_s2_fault", 32'(s2_fault), 32'd0);

        // Streaming: 2-cycle first latency, then one instruction per cycle.
        step(1);
        fetch_req_ready = 1'b1; s2_ready = 1'b1;
        step(12);
        chk("first_latency", 32'(first_pop - first_acc), 32'd2);
        n0 = pop_cnt;
        step(16);
        chk("throughput", 32'(pop_cnt - n0), 32'd16);

        // Queue fills to depth with stage 2 stalled; one pop admits one request.
        s2_ready = 1'b0;
        do_reset();
        a0 = acc_cnt;
        step(20);
        @(negedge clk);
        chk("full_accepts", 32'(acc_cnt - a0), 32'd4);
        chk("full_count", 32'(fq_count), 32'd4);
        chk("full_req_valid", 32'(fetch_req_valid), 32'd0);
        step(1); s2_ready = 1'b1;
        step(1); s2_ready = 1'b0;
        step(10);
        chk("one_more_accept", 32'(acc_cnt - a0), 32'd5);

        // Redirect while a request is outstanding.
        lat_min = 4; lat_max = 4;
        do_reset();
        a0 = acc_cnt;
        wait_acc(a0 + 2);
        redirect_valid = 1'b1; redirect_addr = 32'h0000_1003;
        step(1);
        redirect_valid = 1'b0; s2_ready = 1'b1;
        acc_addrs.delete();
        @(negedge clk);
        chk("redirect_flush", 32'(fq_count), 32'd0);
        step(12);
        chk("redirect_target", acc_at(0), 32'h0000_1000);

        // Fault at 0x20 stops issue until a redirect.
        lat_min = 1; lat_max = 1; fault_addr = 32'h20;
        do_reset();
        a0 = acc_cnt;
        step(30);
        chk("fault_accepts", 32'(acc_cnt - a0), 32'd9);
        chk("fault_last_req", acc_at(acc_addrs.size() - 1), 32'h20);
        chk("fault_s2_pc", last_pop_pc, 32'h20);
        chk("fault_s2_flag", 32'(last_pop_fault), 32'd1);
        fault_addr = 32'h2;
        acc_addrs.delete();
        redirect_valid = 1'b1; redirect_addr = 32'h80;
        step(1);
        redirect_valid = 1'b0;
        step(5);
        chk("fault_resume", acc_at(0), 32'h80);

        // Halt raised while waiting on a response.
        lat_min = 4; lat_max = 4;
        do_reset();
        a0 = acc_cnt;
        wait_acc(a0 + 1);
        halt_req = 1'b1;
        @(negedge clk);
        chk("halt_pending", 32'(halted), 32'd0);
        step(8);
        @(negedge clk);
        chk("halt_reached", 32'(halted), 32'd1);
        chk("halt_no_issue", 32'(acc_cnt - a0), 32'd1);
        step(1);
        halt_req = 1'b0;
        step(8);
        chk("halt_resume", acc_at(1), 32'h4);

        // PC wraps past the top of the address space.
        lat_min = 1; lat_max = 1;
        do_reset();
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFE;
        step(1);
        redirect_valid = 1'b0;
        step(6);
        chk("wrap_first", acc_at(0), 32'hFFFF_FFFC);
        chk("wrap_next", acc_at(1), 32'h0000_0000);

        // Randomized traffic against the reference model.
        lat_min = 1; lat_max = 3; fault_pct = 4;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            rst             = ($urandom_range(0, 499) == 0);
            redirect_valid  = ($urandom_range(0, 99) < 4);
            redirect_addr   = {22'd0, 10'($urandom)};
            if ($urandom_range(0, 19) == 0) halt_req = !halt_req;
            fetch_req_ready = ($urandom_range(0, 3) != 0);
            s2_ready        = ($urandom_range(0, 9) < 6);
        end
        step(1);
        rst = 1'b0; halt_req = 1'b0; fault_pct = 0;
        fetch_req_ready = 1'b1; s2_ready = 1'b1;
        redirect_valid = 1'b1; redirect_addr = 32'h400;
        step(1);
        redirect_valid = 1'b0;
        step(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
